// File: rtl/snes_button_events.sv
// Debounces SNES controller frames into a held-button vector and queues per-button press/release events.
// Latency: btn_state 1 cycle after accepting strobe, first event 1 cycle later; backpressure drops events into sticky evt_overflow.
module snes_button_events #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int FIFO_DEPTH      = 8,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int WATCHDOG_CYCLES = 200000
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        frame_strobe,
    input  logic [15:0] btn_word,
    output logic [11:0] btn_state,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [4:0]  evt_data,
    output logic        evt_overflow,
    input  logic        ovf_clear,
    output logic        ctrl_stale
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES) + 1;
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES - 1);
    localparam logic [WW-1:0] WD_MAX  = WW'(WATCHDOG_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [11:0]   cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   btn_state_q, btn_state_d;
    logic [11:0]   pend_mask_q, pend_mask_d;
    logic [11:0]   pend_val_q, pend_val_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          stale_q, stale_d;
    logic          force_rel_q, force_rel_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [4:0]    mem_d [FIFO_DEPTH];

    logic [11:0]   raw;
    logic [CW-1:0] ncnt;
    logic [11:0]   diff;
    logic [3:0]    sel;
    logic          expire;
    logic          push, push_ok, pop, full, empty;
    logic [4:0]    push_dat;

    // Upper nibble of the frame carries no buttons.
    logic unused_hi;
    assign unused_hi = ^btn_word[15:12];

    assign raw   = ACTIVE_LOW ? ~btn_word[11:0] : btn_word[11:0];
    assign diff  = raw ^ btn_state_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && evt_ready;

    always_comb begin
        ncnt = '0;
        if (raw == cand_q) begin
            ncnt = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        end
    end

    always_comb begin
        sel = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (pend_mask_q[i]) sel = 4'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        btn_state_d = btn_state_q;
        pend_mask_d = pend_mask_q;
        pend_val_d  = pend_val_q;
        force_rel_d = force_rel_q;
        push        = 1'b0;
        push_dat    = 5'd0;

        // A strobe in the same cycle as expiry keeps the controller alive.
        expire = !frame_strobe && (wd_q == WD_LAST);
        if (frame_strobe)        wd_d = '0;
        else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
        else                     wd_d = wd_q;

        if (frame_strobe) stale_d = 1'b0;
        else if (expire)  stale_d = 1'b1;
        else              stale_d = stale_q;

        if (expire) begin
            cand_d = '0;
            cnt_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (force_rel_q || expire) begin
                    force_rel_d = 1'b0;
                    if (btn_state_q != 12'd0) begin
                        pend_mask_d = btn_state_q;
                        pend_val_d  = 12'd0;
                        btn_state_d = 12'd0;
                        state_d     = SCAN;
                    end
                end else if (frame_strobe) begin
                    cand_d = raw;
                    cnt_d  = ncnt;
                    if (ncnt == CNT_MAX) begin
                        btn_state_d = raw;
                        if (diff != 12'd0) begin
                            pend_mask_d = diff;
                            pend_val_d  = raw;
                            state_d     = SCAN;
                        end
                    end
                end
            end
            default: begin
                push        = 1'b1;
                push_dat    = {pend_val_q[sel], sel};
                pend_mask_d = pend_mask_q & ~(12'd1 << sel);
                if (pend_mask_d == 12'd0) state_d = IDLE;
                if (expire) force_rel_d = 1'b1;
            end
        endcase
    end

    // Full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

        if (push && !push_ok) ovf_d = 1'b1;
        else if (ovf_clear)   ovf_d = 1'b0;
        else                  ovf_d = ovf_q;
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            btn_state_q <= '0;
            pend_mask_q <= '0;
            pend_val_q  <= '0;
            wd_q        <= '0;
            stale_q     <= 1'b0;
            force_rel_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            btn_state_q <= btn_state_d;
            pend_mask_q <= pend_mask_d;
            pend_val_q  <= pend_val_d;
            wd_q        <= wd_d;
            stale_q     <= stale_d;
            force_rel_q <= force_rel_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
        end
    end

    assign btn_state    = btn_state_q;
    assign evt_valid    = !empty;
    assign evt_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_overflow = ovf_q;
    assign ctrl_stale   = stale_q;

endmodule

// File: tb/tb_snes_button_events.sv
// Directed bench for snes_button_events: vector table for debounce/event ordering plus hand sequences for FIFO, watchdog and reset.
module tb_snes_button_events;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_strobe = 1'b0;
    logic [15:0] btn_word = 16'hFFFF;
    logic [11:0] btn_state;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [4:0]  evt_data;
    logic        evt_overflow;
    logic        ovf_clear = 1'b0;
    logic        ctrl_stale;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [4:0] ev_q[$];
    int         cy_q[$];

    snes_button_events #(
        .DEBOUNCE_FRAMES(2),
        .FIFO_DEPTH(8),
        .ACTIVE_LOW(1'b1),
        .WATCHDOG_CYCLES(100)
    ) dut (
        .clk_100M(clk),
        .rst_n(rst_n),
        .frame_strobe(frame_strobe),
        .btn_word(btn_word),
        .btn_state(btn_state),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_data(evt_data),
        .evt_overflow(evt_overflow),
        .ovf_clear(ovf_clear),
        .ctrl_stale(ctrl_stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && evt_valid && evt_ready) begin
            ev_q.push_back(evt_data);
            cy_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] w);
        @(negedge clk);
        frame_strobe = 1'b1;
        btn_word = w;
        @(negedge clk);
        frame_strobe = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_q();
        ev_q.delete();
        cy_q.delete();
    endtask

    typedef struct {
        logic [15:0] word;
        int          reps;
        logic [11:0] st;
        int          n;
        logic [14:0] evs;   // event k at evs[k*5 +: 5]
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{16'hFFFE, 2, 12'h001, 1, {10'h0, 5'h10}};
        tbl[1] = '{16'hFFFF, 2, 12'h000, 1, {10'h0, 5'h00}};
        tbl[2] = '{16'hFFFE, 1, 12'h000, 0, 15'h0};
        tbl[3] = '{16'hFFFF, 2, 12'h000, 0, 15'h0};
        tbl[4] = '{16'hF7F6, 2, 12'h809, 3, {5'h1B, 5'h13, 5'h10}};
        tbl[5] = '{16'hFFFF, 2, 12'h000, 3, {5'h0B, 5'h03, 5'h00}};
        tbl[6] = '{16'h0FFF, 2, 12'h000, 0, 15'h0};
        tbl[7] = '{16'hFFDF, 2, 12'h020, 1, {10'h0, 5'h15}};
        tbl[8] = '{16'hFFCF, 2, 12'h030, 1, {10'h0, 5'h14}};
        tbl[9] = '{16'hFFEF, 2, 12'h010, 1, {10'h0, 5'h05}};

        #1;
        check("reset_btn_state", int'(btn_state), 0);
        check("reset_evt_valid", int'(evt_valid), 0);
        check("reset_evt_data", int'(evt_data), 0);
        check("reset_overflow", int'(evt_overflow), 0);
        check("reset_stale", int'(ctrl_stale), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        evt_ready = 1'b1;
        for (int v = 0; v < 10; v++) begin
            clear_q();
            for (int r = 0; r < tbl[v].reps; r++) begin
                strobe(tbl[v].word);
                repeat (15) @(negedge clk);
            end
            check($sformatf("vec%0d_state", v), int'(btn_state), int'(tbl[v].st));
            check($sformatf("vec%0d_nevt", v), ev_q.size(), tbl[v].n);
            for (int k = 0; k < tbl[v].n && k < ev_q.size(); k++) begin
                check($sformatf("vec%0d_evt%0d", v, k), int'(ev_q[k]), int'(tbl[v].evs[k*5 +: 5]));
                if (k > 0)
                    check($sformatf("vec%0d_gap%0d", v, k), cy_q[k] - cy_q[k-1], 1);
            end
        end

        // One-cycle acceptance latency, then first event one cycle later.
        do_reset();
        evt_ready = 1'b0;
        strobe(16'hFFFE);
        strobe(16'hFFFE);
        check("lat_state", int'(btn_state), 12'h001);
        check("lat_valid_early", int'(evt_valid), 0);
        @(negedge clk);
        check("lat_valid", int'(evt_valid), 1);
        check("lat_data", int'(evt_data), 5'h10);
        @(negedge clk);
        check("lat_hold", int'(evt_valid), 1);
        evt_ready = 1'b1;
        @(negedge clk);
        check("lat_popped", int'(evt_valid), 0);

        // FIFO overflow with consumer stalled.
        do_reset();
        evt_ready = 1'b0;
        strobe(16'hF000);
        strobe(16'hF000);
        repeat (15) @(negedge clk);
        check("ovf_set", int'(evt_overflow), 1);
        check("ovf_state", int'(btn_state), 12'hFFF);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        check("ovf_cleared", int'(evt_overflow), 0);
        clear_q();
        evt_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("ovf_pops", ev_q.size(), 8);
        for (int k = 0; k < 8 && k < ev_q.size(); k++)
            check($sformatf("ovf_evt%0d", k), int'(ev_q[k]), 16 + k);
        check("ovf_empty", int'(evt_valid), 0);

        // Watchdog expiry releases held buttons.
        do_reset();
        evt_ready = 1'b1;
        strobe(16'hFFDF);
        strobe(16'hFFDF);
        repeat (98) @(negedge clk);
        check("wd_not_yet", int'(ctrl_stale), 0);
        check("wd_held", int'(btn_state), 12'h020);
        clear_q();
        repeat (2) @(negedge clk);
        check("wd_stale", int'(ctrl_stale), 1);
        check("wd_released", int'(btn_state), 0);
        repeat (15) @(negedge clk);
        check("wd_nevt", ev_q.size(), 1);
        if (ev_q.size() > 0) check("wd_evt", int'(ev_q[0]), 5'h05);
        strobe(16'hFFFF);
        check("wd_stale_clr", int'(ctrl_stale), 0);

        // Reset in the middle of an event scan.
        do_reset();
        evt_ready = 1'b0;
        strobe(16'hF7F6);
        strobe(16'hF7F6);
        @(posedge clk);
        #1;
        check("mid_first_push", int'(evt_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", int'(btn_state), 0);
        check("mid_rst_valid", int'(evt_valid), 0);
        check("mid_rst_data", int'(evt_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        evt_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_no_stale_evts", ev_q.size(), 0);
        check("mid_valid_after", int'(evt_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
